// File: rtl/gam_connection_controller_pkg.sv
// Shared parameters, edge entry format and controller state encoding for the GAM
// connection controller.
package gam_connection_controller_pkg;

    localparam int unsigned NODE_COUNT  = 8;
    localparam int unsigned CLASS_COUNT = 4;
    localparam int unsigned AGE_MAX     = 5;
    localparam int unsigned AGE_W       = 4;
    localparam int unsigned NODE_W      = $clog2(NODE_COUNT);
    localparam int unsigned CLASS_W     = $clog2(CLASS_COUNT);

    typedef struct packed {
        logic             presence;
        logic [AGE_W-1:0] age;
    } edge_entry_T;

    typedef enum logic [2:0] {
        StIdle,
        StSet1,
        StSet2,
        StConnRd,
        StConnEval,
        StConnWr2,
        StPruneRd,
        StPruneEval
    } ctrl_state_e;

    // Smallest valid node index above cur that is neither skip index; 0 when none is left.
    function automatic logic [NODE_W-1:0] next_scan_idx(input logic [NODE_W-1:0] cur,
                                                        input logic [NODE_W-1:0] skip_a,
                                                        input logic [NODE_W-1:0] skip_b);
        logic [NODE_W-1:0] res;
        res = '0;
        for (int k = NODE_COUNT - 1; k >= 1; k--) begin
            if (k > int'(cur) && k != int'(skip_a) && k != int'(skip_b)) begin
                res = NODE_W'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gam_scan_index_gen.sv
// Ascending node-index scanner over 1..NODE_COUNT-1 that skips two indices latched at init.
module gam_scan_index_gen
    import gam_connection_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              step_i,
    input  logic [NODE_W-1:0] skip_a_i,
    input  logic [NODE_W-1:0] skip_b_i,
    output logic [NODE_W-1:0] idx_o,
    output logic [NODE_W-1:0] idx_next_o,
    output logic              last_o
);

    logic [NODE_W-1:0] idx_q, idx_d;
    logic [NODE_W-1:0] skip_a_q, skip_a_d;
    logic [NODE_W-1:0] skip_b_q, skip_b_d;

    always_comb begin
        idx_d    = idx_q;
        skip_a_d = skip_a_q;
        skip_b_d = skip_b_q;
        if (init_i) begin
            idx_d    = next_scan_idx('0, skip_a_i, skip_b_i);
            skip_a_d = skip_a_i;
            skip_b_d = skip_b_i;
        end else if (step_i) begin
            idx_d = next_scan_idx(idx_q, skip_a_q, skip_b_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            skip_a_q <= '0;
            skip_b_q <= '0;
        end else begin
            idx_q    <= idx_d;
            skip_a_q <= skip_a_d;
            skip_b_q <= skip_b_d;
        end
    end

    assign idx_o      = idx_q;
    assign idx_next_o = idx_d;
    // Uses the latched skips so last_o never depends combinationally on the skip inputs.
    assign last_o     = (next_scan_idx(idx_q, skip_a_q, skip_b_q) == '0);

endmodule

// File: rtl/gam_connection_controller.sv
// Sequencer for the per-class GAM edge RAM: serialises connect requests into edge-set and
// neighbour-ageing writes, and runs prune sweeps that drop old edges and report isolated nodes.
module gam_connection_controller
    import gam_connection_controller_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               conn_req_valid,
    output logic               conn_req_ready,
    input  logic [NODE_W-1:0]  conn_node1,
    input  logic [NODE_W-1:0]  conn_node2,
    input  logic [CLASS_W-1:0] conn_class,
    input  logic               prune_start,
    input  logic [CLASS_W-1:0] prune_class,
    output logic               busy,
    output logic               req_err,
    output logic               prune_done,
    output logic               iso_valid,
    output logic [NODE_W-1:0]  iso_node,
    output logic               mem_en,
    output logic               mem_we,
    output logic [CLASS_W-1:0] mem_class,
    output logic [NODE_W-1:0]  mem_row,
    output logic [NODE_W-1:0]  mem_col,
    output edge_entry_T        mem_wdata,
    input  edge_entry_T        mem_rdata
);

    ctrl_state_e state_q, state_d;

    logic [NODE_W-1:0]  n1_q, n1_d, n2_q, n2_d;
    logic [CLASS_W-1:0] cls_q, cls_d, pcls_q, pcls_d;
    logic               pending_q, pending_d;
    edge_entry_T        upd_q, upd_d, upd;
    logic [NODE_W-1:0]  cnt_q, cnt_d;
    logic               req_err_q, req_err_d;
    logic               done_q, done_d;
    logic               iso_valid_q, iso_valid_d;
    logic [NODE_W-1:0]  iso_node_q, iso_node_d;

    logic               accept, illegal;
    logic               i_init, i_step, j_init, j_step;
    logic [NODE_W-1:0]  i_idx, i_next, i_skip_a, i_skip_b, j_idx, j_next;
    logic               i_last, j_last;
    logic               prune_del, prune_surv, row_end, prune_fin;
    logic               unused_j_next;

    assign conn_req_ready = (state_q == StIdle) && !pending_q && !prune_start;
    assign accept         = conn_req_valid && conn_req_ready;
    assign illegal        = (conn_node1 == conn_node2) || (conn_node1 == '0) ||
                            (conn_node2 == '0) || (32'(conn_node1) >= NODE_COUNT) ||
                            (32'(conn_node2) >= NODE_COUNT) || (32'(conn_class) >= CLASS_COUNT);

    assign upd.presence = 1'b1;
    assign upd.age      = (mem_rdata.age == '1) ? mem_rdata.age : mem_rdata.age + AGE_W'(1);

    assign prune_del  = mem_rdata.presence && (32'(mem_rdata.age) >= AGE_MAX);
    assign prune_surv = mem_rdata.presence && !prune_del;
    assign row_end    = (state_q == StPruneEval) && j_last;
    assign prune_fin  = row_end && i_last;

    // Connect scans skip both endpoints; prune rows scan everything.
    assign i_skip_a = (state_q == StSet2) ? n1_q : '0;
    assign i_skip_b = (state_q == StSet2) ? n2_q : '0;

    gam_scan_index_gen u_i_gen (
        .clk        (clk),
        .rst        (rst),
        .init_i     (i_init),
        .step_i     (i_step),
        .skip_a_i   (i_skip_a),
        .skip_b_i   (i_skip_b),
        .idx_o      (i_idx),
        .idx_next_o (i_next),
        .last_o     (i_last)
    );

    // The column scan skips the diagonal of the row it is entering.
    gam_scan_index_gen u_j_gen (
        .clk        (clk),
        .rst        (rst),
        .init_i     (j_init),
        .step_i     (j_step),
        .skip_a_i   (i_next),
        .skip_b_i   (i_next),
        .idx_o      (j_idx),
        .idx_next_o (j_next),
        .last_o     (j_last)
    );

    assign unused_j_next = ^j_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_init  = 1'b0;
        i_step  = 1'b0;
        j_init  = 1'b0;
        j_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    state_d = StPruneRd;
                    i_init  = 1'b1;
                    j_init  = 1'b1;
                end else if (accept && !illegal) begin
                    state_d = StSet1;
                end
            end
            StSet1: state_d = StSet2;
            StSet2: begin
                i_init  = 1'b1;
                state_d = StConnRd;
            end
            StConnRd: state_d = StConnEval;
            StConnEval: begin
                if (mem_rdata.presence) begin
                    state_d = StConnWr2;
                end else if (i_last) begin
                    state_d = StIdle;
                end else begin
                    i_step  = 1'b1;
                    state_d = StConnRd;
                end
            end
            StConnWr2: begin
                if (i_last) begin
                    state_d = StIdle;
                end else begin
                    i_step  = 1'b1;
                    state_d = StConnRd;
                end
            end
            StPruneRd: state_d = StPruneEval;
            StPruneEval: begin
                if (!j_last) begin
                    j_step  = 1'b1;
                    state_d = StPruneRd;
                end else if (i_last) begin
                    state_d = StIdle;
                end else begin
                    i_step  = 1'b1;
                    j_init  = 1'b1;
                    state_d = StPruneRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_class = '0;
        mem_row   = '0;
        mem_col   = '0;
        mem_wdata = '0;
        unique case (state_q)
            StSet1, StSet2: begin
                mem_en             = 1'b1;
                mem_we             = 1'b1;
                mem_class          = cls_q;
                mem_row            = (state_q == StSet1) ? n1_q : n2_q;
                mem_col            = (state_q == StSet1) ? n2_q : n1_q;
                mem_wdata.presence = 1'b1;
            end
            StConnRd: begin
                mem_en    = 1'b1;
                mem_class = cls_q;
                mem_row   = n1_q;
                mem_col   = i_idx;
            end
            StConnEval: begin
                if (mem_rdata.presence) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_class = cls_q;
                    mem_row   = n1_q;
                    mem_col   = i_idx;
                    mem_wdata = upd;
                end
            end
            StConnWr2: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_class = cls_q;
                mem_row   = i_idx;
                mem_col   = n1_q;
                mem_wdata = upd_q;
            end
            StPruneRd: begin
                mem_en    = 1'b1;
                mem_class = pcls_q;
                mem_row   = i_idx;
                mem_col   = j_idx;
            end
            StPruneEval: begin
                if (prune_del) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_class = pcls_q;
                    mem_row   = i_idx;
                    mem_col   = j_idx;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        n1_d        = accept ? conn_node1 : n1_q;
        n2_d        = accept ? conn_node2 : n2_q;
        cls_d       = accept ? conn_class : cls_q;
        req_err_d   = accept && illegal;
        upd_d       = (state_q == StConnEval) ? upd : upd_q;
        pending_d   = pending_q;
        pcls_d      = pcls_q;
        if (prune_fin) begin
            pending_d = 1'b0;
        end
        // A pulse while a prune is already queued keeps the queued class.
        if (prune_start) begin
            pending_d = 1'b1;
            if (!pending_q || prune_fin) begin
                pcls_d = prune_class;
            end
        end
        cnt_d = cnt_q;
        if (state_q == StPruneEval) begin
            cnt_d = row_end ? '0 : cnt_q + NODE_W'(prune_surv);
        end
        iso_valid_d = row_end && (cnt_q == '0) && !prune_surv;
        iso_node_d  = iso_valid_d ? i_idx : '0;
        done_d      = prune_fin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n1_q        <= '0;
            n2_q        <= '0;
            cls_q       <= '0;
            pcls_q      <= '0;
            pending_q   <= 1'b0;
            upd_q       <= '0;
            cnt_q       <= '0;
            req_err_q   <= 1'b0;
            done_q      <= 1'b0;
            iso_valid_q <= 1'b0;
            iso_node_q  <= '0;
        end else begin
            n1_q        <= n1_d;
            n2_q        <= n2_d;
            cls_q       <= cls_d;
            pcls_q      <= pcls_d;
            pending_q   <= pending_d;
            upd_q       <= upd_d;
            cnt_q       <= cnt_d;
            req_err_q   <= req_err_d;
            done_q      <= done_d;
            iso_valid_q <= iso_valid_d;
            iso_node_q  <= iso_node_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign req_err    = req_err_q;
    assign prune_done = done_q;
    assign iso_valid  = iso_valid_q;
    assign iso_node   = iso_node_q;

endmodule

// File: tb/tb_gam_connection_controller.sv
// Directed bench for gam_connection_controller with a behavioural edge RAM and event monitor.
module tb_gam_connection_controller;
    import gam_connection_controller_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               conn_req_valid, conn_req_ready;
    logic [NODE_W-1:0]  conn_node1, conn_node2;
    logic [CLASS_W-1:0] conn_class, prune_class;
    logic               prune_start, busy, req_err, prune_done, iso_valid;
    logic [NODE_W-1:0]  iso_node, mem_row, mem_col;
    logic               mem_en, mem_we;
    logic [CLASS_W-1:0] mem_class;
    edge_entry_T        mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    gam_connection_controller dut (
        .clk            (clk),
        .rst            (rst),
        .conn_req_valid (conn_req_valid),
        .conn_req_ready (conn_req_ready),
        .conn_node1     (conn_node1),
        .conn_node2     (conn_node2),
        .conn_class     (conn_class),
        .prune_start    (prune_start),
        .prune_class    (prune_class),
        .busy           (busy),
        .req_err        (req_err),
        .prune_done     (prune_done),
        .iso_valid      (iso_valid),
        .iso_node       (iso_node),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_class      (mem_class),
        .mem_row        (mem_row),
        .mem_col        (mem_col),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // Edge RAM model; acts on the falling edge so DUT requests are stable when sampled.
    edge_entry_T        ram [CLASS_COUNT][NODE_COUNT][NODE_COUNT];
    logic               ram_clr, pre_en;
    logic [CLASS_W-1:0] pre_c;
    logic [NODE_W-1:0]  pre_r, pre_col;
    edge_entry_T        pre_d;

    always @(negedge clk) begin
        if (ram_clr) begin
            for (int a = 0; a < CLASS_COUNT; a++)
                for (int b = 0; b < NODE_COUNT; b++)
                    for (int c = 0; c < NODE_COUNT; c++) ram[a][b][c] <= '0;
        end else if (pre_en) begin
            ram[pre_c][pre_r][pre_col] <= pre_d;
        end else if (mem_en && mem_we) begin
            ram[mem_class][mem_row][mem_col] <= mem_wdata;
        end
        if (mem_en && !mem_we) mem_rdata <= ram[mem_class][mem_row][mem_col];
    end

    int cyc = 0;
    int busy_cnt, en_cnt, wr_cnt, err_cnt, done_cnt, iso_cnt, order_bad, idle_en_bad;
    int done_cyc, acc_cyc, last_iso;
    logic [NODE_COUNT-1:0] iso_mask;
    logic mon_clr;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            busy_cnt <= 0; en_cnt <= 0; wr_cnt <= 0; err_cnt <= 0; done_cnt <= 0;
            iso_cnt <= 0; order_bad <= 0; idle_en_bad <= 0; done_cyc <= 0; acc_cyc <= 0;
            last_iso <= 0; iso_mask <= '0;
        end else begin
            if (busy) busy_cnt <= busy_cnt + 1;
            if (mem_en) en_cnt <= en_cnt + 1;
            if (mem_en && mem_we) wr_cnt <= wr_cnt + 1;
            if (mem_en && !busy) idle_en_bad <= idle_en_bad + 1;
            if (req_err) err_cnt <= err_cnt + 1;
            if (prune_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (iso_valid) begin
                iso_cnt  <= iso_cnt + 1;
                iso_mask <= iso_mask | (NODE_COUNT'(1) << iso_node);
                if (int'(iso_node) <= last_iso) order_bad <= order_bad + 1;
                last_iso <= int'(iso_node);
            end
            if (conn_req_valid && conn_req_ready) acc_cyc <= cyc;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int p, input int a);
        edge_entry_T e;
        e.presence = p[0];
        e.age      = AGE_W'(a);
        return 32'(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int c, input int r, input int col, input int a);
        pre_c          = CLASS_W'(c);
        pre_r          = NODE_W'(r);
        pre_col        = NODE_W'(col);
        pre_d.presence = 1'b1;
        pre_d.age      = AGE_W'(a);
        pre_en         = 1'b1;
        tick();
        pre_en         = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 500) begin
            tick();
            k++;
        end
        check(tag, 32'(busy), 0);
    endtask

    task automatic connect(input int n1, input int n2, input int c);
        int k = 0;
        conn_node1     = NODE_W'(n1);
        conn_node2     = NODE_W'(n2);
        conn_class     = CLASS_W'(c);
        conn_req_valid = 1'b1;
        while (!conn_req_ready && k < 400) begin
            tick();
            k++;
        end
        tick();
        conn_req_valid = 1'b0;
        wait_idle("conn_idle");
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 400) begin
            tick();
            k++;
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; conn_req_valid = 1'b0; conn_node1 = '0; conn_node2 = '0; conn_class = '0;
        prune_start = 1'b0; prune_class = '0; pre_en = 1'b0; pre_c = '0; pre_r = '0;
        pre_col = '0; pre_d = '0; ram_clr = 1'b1; mon_clr = 1'b1;
        tick();
        tick();
        ram_clr = 1'b0;
        mon_clr = 1'b0;
        check("rst_ready", 32'(conn_req_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_pulses", 32'({req_err, prune_done, iso_valid}), 0);
        rst = 1'b0;
        tick();

        // Connect on an empty RAM.
        clear_mon();
        connect(1, 2, 0);
        check("c1_e12", 32'(ram[0][1][2]), ent(1, 0));
        check("c1_e21", 32'(ram[0][2][1]), ent(1, 0));
        check("c1_writes", wr_cnt, 2);
        check("c1_accesses", en_cnt, 7);
        check("c1_busy", busy_cnt, 12);
        check("c1_ready", 32'(conn_req_ready), 1);

        // Existing neighbour gets aged.
        clear_mon();
        connect(1, 3, 0);
        check("c2_e12", 32'(ram[0][1][2]), ent(1, 1));
        check("c2_e21", 32'(ram[0][2][1]), ent(1, 1));
        check("c2_e13", 32'(ram[0][1][3]), ent(1, 0));
        check("c2_e31", 32'(ram[0][3][1]), ent(1, 0));
        check("c2_writes", wr_cnt, 4);
        check("c2_busy", busy_cnt, 13);

        // Age saturation at 15; 1-3 ages to 1.
        preload(0, 1, 2, 15);
        preload(0, 2, 1, 15);
        clear_mon();
        connect(1, 4, 0);
        check("c3_e12_sat", 32'(ram[0][1][2]), ent(1, 15));
        check("c3_e21_sat", 32'(ram[0][2][1]), ent(1, 15));
        check("c3_e31", 32'(ram[0][3][1]), ent(1, 1));
        check("c3_e14", 32'(ram[0][1][4]), ent(1, 0));
        check("c3_busy", busy_cnt, 14);
        check("c3_writes", wr_cnt, 6);

        // Illegal requests.
        clear_mon();
        connect(3, 3, 0);
        connect(0, 5, 0);
        tick();
        check("ill_err", err_cnt, 2);
        check("ill_mem_en", en_cnt, 0);
        check("ill_busy", busy_cnt, 0);

        // Prune class 1.
        preload(1, 1, 2, 5);
        preload(1, 2, 1, 5);
        preload(1, 3, 4, 2);
        preload(1, 4, 3, 2);
        clear_mon();
        prune_class = 2'd1;
        prune_start = 1'b1;
        tick();
        prune_start = 1'b0;
        wait_done();
        check("p_done", done_cnt, 1);
        check("p_iso_mask", 32'(iso_mask), 32'hE6);
        check("p_iso_cnt", iso_cnt, 5);
        check("p_iso_order", order_bad, 0);
        check("p_writes", wr_cnt, 2);
        check("p_e12", 32'(ram[1][1][2]), 0);
        check("p_e21", 32'(ram[1][2][1]), 0);
        check("p_e34", 32'(ram[1][3][4]), ent(1, 2));
        check("p_e43", 32'(ram[1][4][3]), ent(1, 2));
        check("p_busy", busy_cnt, 84);
        check("p_idle_en", idle_en_bad, 0);

        // Prune requested mid-connect together with a new request.
        clear_mon();
        conn_node1 = 3'd5; conn_node2 = 3'd6; conn_class = 2'd0; conn_req_valid = 1'b1;
        tick();
        conn_req_valid = 1'b0;
        tick();
        tick();
        check("x_ready_busy", 32'(conn_req_ready), 0);
        prune_class = 2'd2;
        prune_start = 1'b1;
        conn_node1 = 3'd5; conn_node2 = 3'd7; conn_req_valid = 1'b1;
        tick();
        prune_start = 1'b0;
        begin
            int k = 0;
            while (!conn_req_ready && k < 400) begin
                tick();
                k++;
            end
        end
        tick();
        conn_req_valid = 1'b0;
        check("x_conn_first", 32'(ram[0][6][5]), ent(1, 0));
        check("x_done_before", done_cnt, 1);
        check("x_accept_at_done", acc_cyc, done_cyc);
        check("x_iso_mask", 32'(iso_mask), 32'hFE);
        check("x_iso_cnt", iso_cnt, 7);
        wait_idle("x_idle");
        check("x_e75", 32'(ram[0][7][5]), ent(1, 0));
        check("x_e65_aged", 32'(ram[0][6][5]), ent(1, 1));

        // Reset in the middle of a prune.
        prune_class = 2'd1;
        prune_start = 1'b1;
        tick();
        prune_start = 1'b0;
        repeat (20) tick();
        check("r_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("r_busy", 32'(busy), 0);
        check("r_ready", 32'(conn_req_ready), 1);
        check("r_mem", 32'({mem_en, mem_we}), 0);
        check("r_pulses", 32'({req_err, prune_done, iso_valid}), 0);
        check("r_iso_node", 32'(iso_node), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("r_no_resume", 32'(busy), 0);
        check("r_ready_after", 32'(conn_req_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gam_connection_controller.md
Name: gam_connection_controller

Overview:
- Sequencer for the per-class GAM connection (edge) memory.
- Serialises learning-time connect requests into the edge-set and neighbour-ageing writes.
- After learning, runs a prune sweep that removes edges with age >= AGE_MAX and reports nodes left with no connections.
- Drives a single-port edge RAM. It is the only writer of that RAM.

Parameters:
- NODE_COUNT, 8: nodes per class. Index 0 is reserved; valid nodes are 1..NODE_COUNT-1.
- CLASS_COUNT, 4: number of classes.
- AGE_MAX, 5: edges with age >= AGE_MAX are removed by prune.
- AGE_W, 4: age field width. Age saturates at 2^AGE_W-1.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-high reset.
- conn_req_valid in 1: connect request.
- conn_req_ready out 1: request accepted when valid && ready.
- conn_node1 in NODE_W: first node. NODE_W = $clog2(NODE_COUNT).
- conn_node2 in NODE_W: second node.
- conn_class in CLASS_W: class. CLASS_W = $clog2(CLASS_COUNT).
- prune_start in 1: single-cycle pulse requesting a prune of prune_class.
- prune_class in CLASS_W: class to prune, sampled with prune_start.
- busy out 1: operation in progress.
- req_err out 1: one-cycle pulse when a request is dropped as illegal.
- prune_done out 1: one-cycle pulse at the end of a prune.
- iso_valid out 1: one-cycle pulse; iso_node has no surviving edges.
- iso_node out NODE_W: isolated node index.
- mem_en out 1: RAM access strobe.
- mem_we out 1: write enable.
- mem_class out CLASS_W, mem_row out NODE_W, mem_col out NODE_W: entry address.
- mem_wdata out edge_entry_T: write data {presence, age}.
- mem_rdata in edge_entry_T: read data, valid the cycle after a read.

Behaviour:
- Reset: every output is 0 except conn_req_ready = 1. State is IDLE and the pending-prune flag is cleared.
- Reset mid-operation aborts immediately, with no completion writes. RAM contents are not cleared.
- conn_req_ready = (state == IDLE) && !prune_pending && !prune_start.
- prune_start in any state sets prune_pending. A second pulse while pending is absorbed.
- If prune_start and conn_req_valid arrive in the same IDLE cycle, prune wins and the request is not accepted.
- Illegal request: node1 == node2, node1 or node2 is 0 or >= NODE_COUNT, or class >= CLASS_COUNT. It is accepted, req_err pulses the next cycle, and no RAM access occurs.
- Connect FSM:
  - IDLE -> SET1: write (c, n1, n2) = {1, 0}.
  - SET2: write (c, n2, n1) = {1, 0}.
  - Then for i = 1..NODE_COUNT-1, skipping n1 and n2, in ascending order:
    - RD: read (c, n1, i).
    - EVAL: if presence, write (c, n1, i) = {1, age+1 saturating}, then go to WR2; otherwise go to the next i.
    - WR2: write (c, i, n1) with the same data.
  - After the last i, return to IDLE.
  - Connect latency in cycles = 2 + 2*(NODE_COUNT-3) + (number of present neighbours).
- Prune FSM (class latched from prune_class):
  - For row i = 1..NODE_COUNT-1: reset the survivor count, then for j = 1..NODE_COUNT-1 with j != i:
    - RD, then EVAL.
    - If present && age >= AGE_MAX: write (i, j) = {0, 0}, one cycle.
    - Else if present: survivor count += 1.
  - At the end of the row, if the count is 0: iso_valid = 1 and iso_node = i for one cycle, with no extra stall.
  - The matrix is symmetric, so row-wise counting gives the post-prune result.
  - After row NODE_COUNT-1: prune_done pulses, prune_pending clears, and the FSM returns to IDLE.
- busy is high in every non-IDLE state.
- mem_en and mem_we are 0 in IDLE.
- No RAM access is issued in EVAL cycles where no write is needed.

Decomposition:
- GAM_package: NODE_COUNT, CLASS_COUNT, AGE_MAX, AGE_W, edge_entry_T (presence bit, age[AGE_W]), and the controller state enum typedef.
- One sub-module, gam_scan_index_gen: an index counter from 1 to NODE_COUNT-1 with skip-mask inputs (two skip indices), a step input, and a last flag. It is instantiated for i and for j.

Test Plan:
- Connect (c=0, 1, 2) on an empty RAM -> writes (1,2) and (2,1) = {1,0}; no other writes; busy for 12 cycles; ready returns high.
- Connect (0, 1, 3) after edge (1,2) exists with age 0 -> (1,2) and (2,1) become age 1; (1,3) and (3,1) = {1,0}; busy for 13 cycles.
- Preload (1,2) and (2,1) at age 15, then connect (0, 1, 4) -> age stays 15 (saturation).
- Connect (0, 3, 3), then (0, 0, 5) -> req_err pulses twice, no mem_en, busy stays low.
- Preload class 1 with edges 1-2 at age 5 and 3-4 at age 2, then pulse prune_start for class 1 -> 1-2 cleared in both directions; iso_valid for nodes 1, 2, 5, 6, 7 in ascending order; nodes 3 and 4 not reported; prune_done pulses once.
- prune_start during a connect, in the same cycle as a new conn_req_valid -> the connect finishes, the prune runs next, and the request waits until prune_done. Assert rst mid-prune -> outputs return to reset values on the next edge.
